// File: rtl/clock_1_2_pkg.sv
// Shared definitions for the clock_1 / clock_2 pattern generator:
// default period, counter-width helper and period legality check.
package clk12_pkg;

    // Default clock_1 period in system-clock cycles.
    localparam int CLK12_PERIOD_1_DEFAULT = 8;

    // Number of bits needed to hold a phase count of 0 .. period-1.
    function automatic int clk12_cnt_w(input int period);
        int w;
        w = 1;
        while ((1 << w) < period) begin
            w++;
        end
        return w;
    endfunction

    // A period is usable only when it splits into four equal quarter phases.
    function automatic bit clk12_period_legal(input int period);
        return (period >= 4) && ((period % 4) == 0);
    endfunction

endpackage

// File: rtl/clock_1_2_if.sv
// Output bundle of the clock_1 / clock_2 generator.
// The strobe signals exist only when CLK12_STROBE_EN is defined.
interface clock_1_2_if;

    logic clock_1;
    logic clock_2;
`ifdef CLK12_STROBE_EN
    logic clock_1_rise;
    logic clock_2_fall;
`endif

`ifdef CLK12_STROBE_EN
    modport master (output clock_1, output clock_2, output clock_1_rise, output clock_2_fall);
    modport slave  (input  clock_1, input  clock_2, input  clock_1_rise, input  clock_2_fall);
`else
    modport master (output clock_1, output clock_2);
    modport slave  (input  clock_1, input  clock_2);
`endif

endinterface

// File: rtl/clock_1_2_toggle_divider.sv
// Registered level that flips whenever its match input is true.
// Synchronous reset returns the level to 0 and overrides the match.
module toggle_divider (
    input  logic clock,
    input  logic reset,
    input  logic i_match,
    output logic o_level
);

    logic r_level;

    // Hold the level, invert it on a match, clear it on reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_level <= 1'b0;
        end else if (i_match) begin
            r_level <= ~r_level;
        end
    end

    assign o_level = r_level;

endmodule

// File: rtl/clock_1_2.sv
// Two-phase clock-pattern generator.
// clock_1 : square wave, period PERIOD_1 system cycles.
// clock_2 : square wave, period PERIOD_1/2, every clock_1 edge is a clock_2 rise.
// Optional feature macro: CLK12_STROBE_EN adds the registered strobes
// clock_1_rise and clock_2_fall on the interface.
module clock_1_2
    import clk12_pkg::*;
#(
    parameter int PERIOD_1 = CLK12_PERIOD_1_DEFAULT
) (
    input  logic          clock,
    input  logic          reset,
    clock_1_2_if.master   bus
);

    localparam int CNT_W = clk12_cnt_w(PERIOD_1);
    localparam int P     = PERIOD_1 / 4;

    // Phase counts at which a toggle is due: the last cycle of each quarter.
    localparam logic [CNT_W-1:0] C_Q1   = CNT_W'(1 * P - 1);
    localparam logic [CNT_W-1:0] C_Q2   = CNT_W'(2 * P - 1);
    localparam logic [CNT_W-1:0] C_Q3   = CNT_W'(3 * P - 1);
    localparam logic [CNT_W-1:0] C_Q4   = CNT_W'(4 * P - 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PERIOD_1 - 1);

    if (!clk12_period_legal(PERIOD_1)) begin : g_bad_period
        $error("clock_1_2: PERIOD_1 must be a multiple of 4 and at least 4");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             w_match_1;
    logic             w_match_2;
    logic             w_clock_1;
    logic             w_clock_2;

    // Free-running phase counter, 0 .. PERIOD_1-1, restarted by reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // clock_2 toggles at the end of every quarter; clock_1 at the end of
    // quarters 1 and 3, so each clock_1 edge lands on a clock_2 rise.
    always_comb begin
        w_match_2 = 1'b0;
        w_match_1 = 1'b0;
        w_match_2 = (r_cnt == C_Q1) || (r_cnt == C_Q2) ||
                    (r_cnt == C_Q3) || (r_cnt == C_Q4);
        w_match_1 = (r_cnt == C_Q1) || (r_cnt == C_Q3);
    end

    toggle_divider u_div_1 (
        .clock   (clock),
        .reset   (reset),
        .i_match (w_match_1),
        .o_level (w_clock_1)
    );

    toggle_divider u_div_2 (
        .clock   (clock),
        .reset   (reset),
        .i_match (w_match_2),
        .o_level (w_clock_2)
    );

    assign bus.clock_1 = w_clock_1;
    assign bus.clock_2 = w_clock_2;

`ifdef CLK12_STROBE_EN
    logic r_clock_1_rise;
    logic r_clock_2_fall;

    // Strobes are registered on the same edge as the level change they mark,
    // so each is high exactly in the cycle the new level first appears.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_clock_1_rise <= 1'b0;
            r_clock_2_fall <= 1'b0;
        end else begin
            r_clock_1_rise <= w_match_1 && !w_clock_1;
            r_clock_2_fall <= w_match_2 &&  w_clock_2;
        end
    end

    assign bus.clock_1_rise = r_clock_1_rise;
    assign bus.clock_2_fall = r_clock_2_fall;
`endif

endmodule

// File: tb/tb_clock_1_2.sv
// Directed bench for clock_1_2: instances with PERIOD_1 = 8, 4 and 16.
// Strobe checks are included when CLK12_STROBE_EN is defined.
module tb_clock_1_2;

    logic clk = 1'b0;
    logic rst8 = 1'b1;
    logic rst4 = 1'b1;
    logic rst16 = 1'b1;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    clock_1_2_if if8();
    clock_1_2_if if4();
    clock_1_2_if if16();

    clock_1_2 #(.PERIOD_1(8))  u_dut8  (.clock(clk), .reset(rst8),  .bus(if8));
    clock_1_2 #(.PERIOD_1(4))  u_dut4  (.clock(clk), .reset(rst4),  .bus(if4));
    clock_1_2 #(.PERIOD_1(16)) u_dut16 (.clock(clk), .reset(rst16), .bus(if16));

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int e1_8 [10] = '{0, 1, 1, 1, 1, 0, 0, 0, 0, 1};
        int e2_8 [10] = '{0, 1, 1, 0, 0, 1, 1, 0, 0, 1};
        int e1_4 [8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
        int e2_4 [8]  = '{1, 0, 1, 0, 1, 0, 1, 0};
        int run1, run2;
        logic prev1, prev2, c1, c2;

        // Reset state on every instance.
        repeat (3) tick();
        chk("rst8_c1",  int'(if8.clock_1),  0);
        chk("rst8_c2",  int'(if8.clock_2),  0);
        chk("rst4_c1",  int'(if4.clock_1),  0);
        chk("rst4_c2",  int'(if4.clock_2),  0);
        chk("rst16_c1", int'(if16.clock_1), 0);
        chk("rst16_c2", int'(if16.clock_2), 0);
`ifdef CLK12_STROBE_EN
        chk("rst16_rise", int'(if16.clock_1_rise), 0);
        chk("rst16_fall", int'(if16.clock_2_fall), 0);
`endif

        // PERIOD_1 = 8 start-up sequence, k = 1..10.
        rst8 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk($sformatf("p8_c1_k%0d", k), int'(if8.clock_1), e1_8[k-1]);
            chk($sformatf("p8_c2_k%0d", k), int'(if8.clock_2), e2_8[k-1]);
        end

        // Free run: both levels just changed at k = 10.
        prev1 = if8.clock_1;
        prev2 = if8.clock_2;
        run1 = 1;
        run2 = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            c1 = if8.clock_1;
            c2 = if8.clock_2;
            if (c1 != prev1) begin
                chk("p8_run_c1", run1, 4);
                chk("p8_c1_edge_on_c2_rise", int'(c2 & ~prev2), 1);
                run1 = 1;
            end else begin
                run1++;
            end
            if (c2 != prev2) begin
                chk("p8_run_c2", run2, 2);
                run2 = 1;
            end else begin
                run2++;
            end
            prev1 = c1;
            prev2 = c2;
        end

        // Reset asserted at k = 5 for one cycle, then restart.
        rst8 = 1'b1;
        tick();
        rst8 = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        chk("mid_pre_c1", int'(if8.clock_1), 1);
        chk("mid_pre_c2", int'(if8.clock_2), 0);
        rst8 = 1'b1;
        tick();
        chk("mid_rst_c1", int'(if8.clock_1), 0);
        chk("mid_rst_c2", int'(if8.clock_2), 0);
        rst8 = 1'b0;
        tick();
        chk("mid_k1_c1", int'(if8.clock_1), 0);
        chk("mid_k1_c2", int'(if8.clock_2), 0);
        tick();
        chk("mid_k2_c1", int'(if8.clock_1), 1);
        chk("mid_k2_c2", int'(if8.clock_2), 1);

        // PERIOD_1 = 4: clock_2 toggles every cycle.
        rst4 = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk($sformatf("p4_c1_k%0d", k), int'(if4.clock_1), e1_4[k-1]);
            chk($sformatf("p4_c2_k%0d", k), int'(if4.clock_2), e2_4[k-1]);
        end

        // PERIOD_1 = 16, k = 1..40.
        rst16 = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            chk($sformatf("p16_c1_k%0d", k), int'(if16.clock_1), ((k + 4) / 8) % 2);
            chk($sformatf("p16_c2_k%0d", k), int'(if16.clock_2), (k / 4) % 2);
`ifdef CLK12_STROBE_EN
            chk($sformatf("p16_rise_k%0d", k), int'(if16.clock_1_rise),
                (k == 4 || k == 20 || k == 36) ? 1 : 0);
            chk($sformatf("p16_fall_k%0d", k), int'(if16.clock_2_fall),
                (k % 8 == 0) ? 1 : 0);
`endif
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
